// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the cs147sec05 processor control unit.
// Holds the CTRL bit map, the instruction opcode/funct values, the ALU
// operation codes, the FSM state encoding and the decoded-instruction record
// passed from proc_ctrl_decode to the FSM. No ports (package).
package proc_ctrl_pkg;

  localparam int CTRL_W = 32;

  // CTRL bit positions
  localparam int PC_LOAD   = 0;
  localparam int PC_SEL_LO = 1;   // pc_sel_1..3 occupy bits 3:1
  localparam int PC_SEL_HI = 3;
  localparam int MEM_R     = 4;
  localparam int MEM_W     = 5;
  localparam int R1_SEL_1  = 6;
  localparam int REG_R     = 7;
  localparam int REG_W     = 8;
  localparam int WA_SEL_LO = 9;   // wa_sel_1..3 occupy bits 11:9
  localparam int WA_SEL_HI = 11;
  localparam int WD_SEL_LO = 12;  // wd_sel_1..3 occupy bits 14:12
  localparam int WD_SEL_HI = 14;
  localparam int SP_LOAD   = 15;
  localparam int OP1_SEL_1 = 16;
  localparam int OP2_SEL_LO = 17; // op2_sel_1..4 occupy bits 20:17
  localparam int OP2_SEL_HI = 20;
  localparam int ALU_LO    = 21;
  localparam int ALU_HI    = 25;
  localparam int MA_SEL_1  = 26;
  localparam int DMEM_R    = 27;
  localparam int DMEM_W    = 28;
  localparam int MD_SEL_1  = 29;
  localparam int IR_LOAD   = 30;
  localparam int MA_SEL_2  = 31;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;

  // R-type functs
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  // ALU operation codes
  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_MUL  = 5'd3;
  localparam logic [4:0] ALU_SRL  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd6;
  localparam logic [4:0] ALU_OR   = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;

  // Select field values, written MSB-first as {sel_3, sel_2, sel_1} / {sel_4..sel_1}
  localparam logic [3:0] OP2_REG   = 4'b1000;
  localparam logic [3:0] OP2_SIMM  = 4'b0010;
  localparam logic [3:0] OP2_ZIMM  = 4'b0000;
  localparam logic [3:0] OP2_SHAMT = 4'b0101;
  localparam logic [3:0] OP2_ONE   = 4'b0100;

  localparam logic [2:0] PC_SEQ    = 3'b101;
  localparam logic [2:0] PC_BRANCH = 3'b111;
  localparam logic [2:0] PC_JR     = 3'b100;
  localparam logic [2:0] PC_JUMP   = 3'b001;

  localparam logic [2:0] WA_RD  = 3'b100;
  localparam logic [2:0] WA_RT  = 3'b101;
  localparam logic [2:0] WA_R31 = 3'b010;
  localparam logic [2:0] WA_R0  = 3'b000;

  localparam logic [2:0] WD_ALU = 3'b100;
  localparam logic [2:0] WD_LUI = 3'b110;
  localparam logic [2:0] WD_MEM = 3'b101;
  localparam logic [2:0] WD_PC1 = 3'b000;

  // Everything the FSM needs to know about the instruction in IR.
  typedef struct packed {
    logic       r1_sel_1;
    logic       op1_sel_1;
    logic [3:0] op2_sel;
    logic [4:0] alu_oprn;
    logic       sp_load_exe;
    logic       mem_r;
    logic       mem_w;
    logic       ma_sel_1;
    logic       md_sel_1;
    logic       mem_r_wb;
    logic       reg_w;
    logic [2:0] wa_sel;
    logic [2:0] wd_sel;
    logic       sp_load_wb;
    logic [2:0] pc_sel;
    logic       is_beq;
    logic       is_bne;
  } dec_t;

  // ALU operation for the arithmetic/logic R-type functs; anything else is none.
  function automatic logic [4:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_MUL:  return ALU_MUL;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational instruction decoder for the control unit.
// Ports:
//   opcode - IR[31:26]
//   funct  - IR[5:0]
//   dec    - per-instruction selects, strobes and ALU operation; the FSM
//            decides in which state each field actually reaches CTRL.
// Unknown opcodes/functs decode to a NOP: sequential PC, no write strobes.
module proc_ctrl_decode
  import proc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.r1_sel_1 = 1'b1;
    dec.pc_sel   = PC_SEQ;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_MUL, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL: begin
            // Shifts take the shamt field as operand 2, the rest use rt.
            dec.op2_sel  = (funct == FN_SLL || funct == FN_SRL) ? OP2_SHAMT : OP2_REG;
            dec.alu_oprn = funct_to_alu(funct);
            dec.reg_w    = 1'b1;
            dec.wa_sel   = WA_RD;
            dec.wd_sel   = WD_ALU;
          end
          FN_JR:   dec.pc_sel = PC_JR;
          default: ;
        endcase
      end
      OP_ADDI, OP_MULI, OP_SLTI, OP_ANDI, OP_ORI: begin
        case (opcode)
          OP_ADDI: dec.alu_oprn = ALU_ADD;
          OP_MULI: dec.alu_oprn = ALU_MUL;
          OP_SLTI: dec.alu_oprn = ALU_SLT;
          OP_ANDI: dec.alu_oprn = ALU_AND;
          default: dec.alu_oprn = ALU_OR;
        endcase
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        dec.op2_sel = (opcode == OP_ANDI || opcode == OP_ORI) ? OP2_ZIMM : OP2_SIMM;
        dec.reg_w   = 1'b1;
        dec.wa_sel  = WA_RT;
        dec.wd_sel  = WD_ALU;
      end
      OP_LUI: begin
        dec.reg_w  = 1'b1;
        dec.wa_sel = WA_RT;
        dec.wd_sel = WD_LUI;
      end
      OP_BEQ, OP_BNE: begin
        dec.op2_sel  = OP2_REG;
        dec.alu_oprn = ALU_SUB;
        dec.is_beq   = (opcode == OP_BEQ);
        dec.is_bne   = (opcode == OP_BNE);
      end
      OP_LW: begin
        dec.op2_sel  = OP2_SIMM;
        dec.alu_oprn = ALU_ADD;
        dec.mem_r    = 1'b1;
        dec.reg_w    = 1'b1;
        dec.wa_sel   = WA_RT;
        dec.wd_sel   = WD_MEM;
      end
      OP_SW: begin
        dec.op2_sel  = OP2_SIMM;
        dec.alu_oprn = ALU_ADD;
        dec.mem_w    = 1'b1;
      end
      OP_JMP: dec.pc_sel = PC_JUMP;
      OP_JAL: begin
        dec.pc_sel = PC_JUMP;
        dec.reg_w  = 1'b1;
        dec.wa_sel = WA_R31;
        dec.wd_sel = WD_PC1;
      end
      OP_PUSH: begin
        // push stores R0 at SP-1, then SP takes the decremented value.
        dec.r1_sel_1   = 1'b0;
        dec.op1_sel_1  = 1'b1;
        dec.op2_sel    = OP2_ONE;
        dec.alu_oprn   = ALU_SUB;
        dec.mem_w      = 1'b1;
        dec.ma_sel_1   = 1'b1;
        dec.md_sel_1   = 1'b1;
        dec.sp_load_wb = 1'b1;
      end
      OP_POP: begin
        // pop bumps SP in EXE, reads memory in MEM and writes R0 in WB.
        dec.op1_sel_1   = 1'b1;
        dec.op2_sel     = OP2_ONE;
        dec.alu_oprn    = ALU_ADD;
        dec.sp_load_exe = 1'b1;
        dec.mem_r       = 1'b1;
        dec.ma_sel_1    = 1'b1;
        dec.mem_r_wb    = 1'b1;
        dec.reg_w       = 1'b1;
        dec.wa_sel      = WA_R0;
        dec.wd_sel      = WD_MEM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Five-state (FETCH, DECODE, EXE, MEM, WB) control unit of the cs147sec05
// processor. Captures the instruction in FETCH and the ALU zero flag in EXE,
// and builds the CTRL word for the data path from state, IR and zero_q.
// Ports:
//   CLK         - clock, rising edge
//   RST         - asynchronous active-low reset
//   INSTRUCTION - instruction word, valid during FETCH
//   ZERO        - ALU zero flag, sampled on the edge leaving EXE
//   CTRL        - control word to the data path
//   STATE       - current state encoding
module proc_control_fsm
  import proc_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic [2:0]        STATE
);

  state_t      state;
  state_t      next_state;
  logic [31:0] ir;
  logic        zero_q;
  dec_t        dec;
  logic        branch_taken;
  logic        in_decode_on;
  logic        in_exe_on;

  // The register/immediate fields of IR are consumed by the data path only.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[25:6];

  proc_ctrl_decode u_decode (
    .opcode (ir[31:26]),
    .funct  (ir[5:0]),
    .dec    (dec)
  );

  // State, IR and zero flag registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= ST_FETCH;
      ir     <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH) ir <= INSTRUCTION;
      if (state == ST_EXE)   zero_q <= ZERO;
    end
  end

  // Fixed five-step sequence; illegal encodings fall back to FETCH.
  always_comb begin
    next_state = ST_FETCH;
    case (state)
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXE;
      ST_EXE:    next_state = ST_MEM;
      ST_MEM:    next_state = ST_WB;
      default:   next_state = ST_FETCH;
    endcase
  end

  // CTRL: register-read bits stay up from DECODE onward and ALU/operand
  // selects from EXE onward, so the data path sees stable operands while the
  // memory access and write-back happen. Reset forces the word to zero.
  always_comb begin
    CTRL         = '0;
    branch_taken = (dec.is_beq && zero_q) || (dec.is_bne && !zero_q);
    in_decode_on = (state == ST_DECODE) || (state == ST_EXE) ||
                   (state == ST_MEM) || (state == ST_WB);
    in_exe_on    = (state == ST_EXE) || (state == ST_MEM) || (state == ST_WB);

    if (state == ST_FETCH) begin
      CTRL[MA_SEL_2] = 1'b1;
      CTRL[MEM_R]    = 1'b1;
      CTRL[IR_LOAD]  = 1'b1;
    end
    if (in_decode_on) begin
      CTRL[REG_R]    = 1'b1;
      CTRL[R1_SEL_1] = dec.r1_sel_1;
    end
    if (in_exe_on) begin
      CTRL[OP1_SEL_1]             = dec.op1_sel_1;
      CTRL[OP2_SEL_HI:OP2_SEL_LO] = dec.op2_sel;
      CTRL[ALU_HI:ALU_LO]         = dec.alu_oprn;
    end
    case (state)
      ST_EXE: CTRL[SP_LOAD] = dec.sp_load_exe;
      ST_MEM: begin
        CTRL[MEM_R]    = dec.mem_r;
        CTRL[MEM_W]    = dec.mem_w;
        CTRL[MA_SEL_1] = dec.ma_sel_1;
        CTRL[MD_SEL_1] = dec.md_sel_1;
      end
      ST_WB: begin
        CTRL[PC_LOAD]             = 1'b1;
        CTRL[PC_SEL_HI:PC_SEL_LO] = branch_taken ? PC_BRANCH : dec.pc_sel;
        CTRL[REG_W]               = dec.reg_w;
        CTRL[WA_SEL_HI:WA_SEL_LO] = dec.wa_sel;
        CTRL[WD_SEL_HI:WD_SEL_LO] = dec.wd_sel;
        CTRL[SP_LOAD]             = dec.sp_load_wb;
        CTRL[MEM_R]               = dec.mem_r_wb;
      end
      default: ;
    endcase
    if (!RST) CTRL = '0;
  end

  assign STATE = state;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm. Each instruction vector lists the
// expected CTRL word for DECODE, EXE, MEM and WB; expectations are queued per
// cycle and popped when the DUT output is sampled mid-cycle.
module tb_proc_control_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic [2:0]  STATE;

  localparam logic [31:0] FETCH_CTRL = 32'hC000_0010;

  typedef struct {
    logic [2:0]  state;
    logic [31:0] ctrl;
    string       tag;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic [31:0] dec_c;
    logic [31:0] exe_c;
    logic [31:0] mem_c;
    logic [31:0] wb_c;
  } vec_t;

  exp_t scoreboard[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  proc_control_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .CTRL        (CTRL),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic void addVec(string name, logic [31:0] instr, logic zero,
                                 logic [31:0] d, logic [31:0] e,
                                 logic [31:0] m, logic [31:0] w);
    vec_t v;
    v.name  = name;
    v.instr = instr;
    v.zero  = zero;
    v.dec_c = d;
    v.exe_c = e;
    v.mem_c = m;
    v.wb_c  = w;
    vecs.push_back(v);
  endfunction

  function automatic void pushExpected(logic [2:0] st, logic [31:0] c, string tag);
    exp_t e;
    e.state = st;
    e.ctrl  = c;
    e.tag   = tag;
    scoreboard.push_back(e);
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty: got CTRL=%h with no expectation", CTRL);
      return;
    end
    e = scoreboard.pop_front();
    checks++;
    if (STATE !== e.state) begin
      failures++;
      $display("[TB] FAIL %s STATE: got %0d expected %0d", e.tag, STATE, e.state);
    end
    checks++;
    if (CTRL !== e.ctrl) begin
      failures++;
      $display("[TB] FAIL %s CTRL: got %h expected %h", e.tag, CTRL, e.ctrl);
    end
  endtask

  function automatic logic [31:0] expFor(vec_t v, int s);
    case (s)
      0:       return FETCH_CTRL;
      1:       return v.dec_c;
      2:       return v.exe_c;
      3:       return v.mem_c;
      default: return v.wb_c;
    endcase
  endfunction

  // Drives one cycle of a vector. INSTRUCTION is only meaningful in FETCH and
  // ZERO only in EXE; other cycles carry inverted values so mistimed capture shows.
  task automatic driveCycle(vec_t v, int s);
    INSTRUCTION = (s == 0) ? v.instr : ~v.instr;
    ZERO        = (s == 2) ? v.zero : ~v.zero;
    pushExpected(3'(s), expFor(v, s), $sformatf("%s/s%0d", v.name, s));
    #1 checkOutput();
  endtask

  // Runs one full instruction starting at a negedge while in FETCH.
  task automatic applyStimulus(vec_t v);
    for (int s = 0; s < 5; s++) begin
      driveCycle(v, s);
      @(negedge CLK);
    end
  endtask

  // Runs an instruction up to abort_state, pulls RST low there and checks the
  // unit drops to FETCH with CTRL cleared, then restarts with a NOP.
  task automatic abortSequence(vec_t v, int abort_state, vec_t nop);
    for (int s = 0; s <= abort_state; s++) begin
      driveCycle(v, s);
      if (s < abort_state) @(negedge CLK);
    end
    RST = 1'b0;
    pushExpected(3'd0, 32'h0, {v.name, "/abort"});
    #1 checkOutput();
    @(posedge CLK);
    pushExpected(3'd0, 32'h0, {v.name, "/abort_held"});
    #1 checkOutput();
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(nop);
  endtask

  initial begin
    vec_t nop;
    RST         = 1'b0;
    INSTRUCTION = 32'h0;
    ZERO        = 1'b0;

    pushExpected(3'd0, 32'h0, "reset_async");
    #1 checkOutput();
    @(negedge CLK);
    pushExpected(3'd0, 32'h0, "reset_held");
    #1 checkOutput();
    RST = 1'b1;

    //     name         instr          z     DECODE        EXE           MEM           WB
    addVec("add",       32'h0043_0820, 1'b0, 32'h0000_00C0, 32'h0030_00C0, 32'h0030_00C0, 32'h0030_49CB);
    addVec("sub",       32'h0043_0822, 1'b1, 32'h0000_00C0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_49CB);
    addVec("mul",       32'h0043_082C, 1'b0, 32'h0000_00C0, 32'h0070_00C0, 32'h0070_00C0, 32'h0070_49CB);
    addVec("sll",       32'h0002_0841, 1'b0, 32'h0000_00C0, 32'h00AA_00C0, 32'h00AA_00C0, 32'h00AA_49CB);
    addVec("addi",      32'h2041_0005, 1'b0, 32'h0000_00C0, 32'h0024_00C0, 32'h0024_00C0, 32'h0024_4BCB);
    addVec("andi",      32'h3041_0005, 1'b0, 32'h0000_00C0, 32'h00C0_00C0, 32'h00C0_00C0, 32'h00C0_4BCB);
    addVec("ori",       32'h3441_0005, 1'b0, 32'h0000_00C0, 32'h00E0_00C0, 32'h00E0_00C0, 32'h00E0_4BCB);
    addVec("slti",      32'h2841_0005, 1'b0, 32'h0000_00C0, 32'h0124_00C0, 32'h0124_00C0, 32'h0124_4BCB);
    addVec("lui",       32'h3C01_0005, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_6BCB);
    addVec("lw",        32'h8C41_0004, 1'b0, 32'h0000_00C0, 32'h0024_00C0, 32'h0024_00D0, 32'h0024_5BCB);
    addVec("sw",        32'hAC41_0004, 1'b0, 32'h0000_00C0, 32'h0024_00C0, 32'h0024_00E0, 32'h0024_00CB);
    addVec("beq_z1",    32'h1022_0003, 1'b1, 32'h0000_00C0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CF);
    addVec("beq_z0",    32'h1022_0003, 1'b0, 32'h0000_00C0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CB);
    addVec("bne_z1",    32'h1422_0003, 1'b1, 32'h0000_00C0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CB);
    addVec("bne_z0",    32'h1422_0003, 1'b0, 32'h0000_00C0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CF);
    addVec("jr",        32'h03E0_0008, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C9);
    addVec("jmp",       32'h0800_0010, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C3);
    addVec("jal",       32'h0C00_0010, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_05C3);
    addVec("push",      32'h6C00_0000, 1'b0, 32'h0000_0080, 32'h0049_0080, 32'h2449_00A0, 32'h0049_808B);
    addVec("pop",       32'h7000_0000, 1'b0, 32'h0000_00C0, 32'h0029_80C0, 32'h0429_00D0, 32'h0029_51DB);
    addVec("op3f",      32'hFC00_0000, 1'b1, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00CB);
    addVec("funct3f",   32'h0043_083F, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00CB);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Instruction word 0 is R-type funct 00, which decodes as a NOP.
    nop.name  = "nop_after_abort";
    nop.instr = 32'h0;
    nop.zero  = 1'b0;
    nop.dec_c = 32'h0000_00C0;
    nop.exe_c = 32'h0000_00C0;
    nop.mem_c = 32'h0000_00C0;
    nop.wb_c  = 32'h0000_00CB;

    // lw aborted in EXE, sw aborted in MEM with its write strobe up.
    abortSequence(vecs[9], 2, nop);
    abortSequence(vecs[10], 3, nop);

    if (scoreboard.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", scoreboard.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
